forwarding_hazard_unit: RTL and testbench

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

---
 rtl/forwarding_hazard_unit.sv | 125 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select and hazard-stall unit. Resolves ID source operands against
// in-flight producers (EXE and the later stages), raises load-use or stall-only hazards, and tracks stall statistics.
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif

module forwarding_hazard_unit #(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned ADDR_W         = `REG_FILE_ADDR_LEN,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned SEL_W = ($clog2(NUM_FWD_STAGES + 1) > 1) ? $clog2(NUM_FWD_STAGES + 1) : 1,
  localparam int unsigned STG_N = (NUM_FWD_STAGES > 1) ? NUM_FWD_STAGES - 1 : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic                       id_valid,
  input  logic [ADDR_W-1:0]          exe_dest,
  input  logic                       exe_wb_en,
  input  logic                       exe_mem_r_en,
  input  logic [STG_N*ADDR_W-1:0]    stg_dest,
  input  logic [STG_N-1:0]           stg_wb_en,
  input  logic                       fwd_en,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   exe_sel,
  output logic                       hazard_stall,
  output logic                       stall_event,
  output logic [CNT_W-1:0]           stall_count
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [NUM_SRC*SEL_W-1:0]    exe_sel_q, exe_sel_d;
  logic                        stall_event_q, stall_event_d;
  logic [CNT_W-1:0]            stall_count_q, stall_count_d;

  logic [ADDR_W-1:0]           prod_dest [NUM_FWD_STAGES];
  logic [NUM_FWD_STAGES-1:0]   prod_we;
  logic [NUM_SRC*SEL_W-1:0]    sel_c;
  logic                        any_exe_c;
  logic                        any_prod_c;
  logic                        hazard_c;

  // Producer table: position 0 is EXE, position k is stg entry k-1.
  always_comb begin
    prod_dest[0] = exe_dest;
    prod_we[0]   = exe_wb_en;
    for (int k = 1; k < int'(NUM_FWD_STAGES); k++) begin
      prod_dest[k] = stg_dest[(k-1)*int'(ADDR_W) +: ADDR_W];
      prod_we[k]   = stg_wb_en[k-1];
    end
  end

  // Scan producers oldest-to-youngest so the nearest match overwrites farther ones.
  always_comb begin
    logic [ADDR_W-1:0] src;
    sel_c      = '0;
    any_exe_c  = 1'b0;
    any_prod_c = 1'b0;
    src        = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src = id_src[i*int'(ADDR_W) +: ADDR_W];
      for (int p = int'(NUM_FWD_STAGES) - 1; p >= 0; p--) begin
        if (id_src_used[i] && (src != '0) && prod_we[p] && (src == prod_dest[p])) begin
          sel_c[i*int'(SEL_W) +: SEL_W] = SEL_W'(p + 1);
          any_prod_c = 1'b1;
          if (p == 0) any_exe_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    hazard_c = 1'b0;
    if (!rst && !flush && id_valid) begin
      if (fwd_en) hazard_c = exe_wb_en && exe_mem_r_en && any_exe_c;
      else        hazard_c = any_prod_c;
    end
  end

  // Next-state, select and statistics logic.
  always_comb begin
    state_d       = state_q;
    exe_sel_d     = '0;
    stall_event_d = 1'b0;
    stall_count_d = stall_count_q;
    if (id_valid && !hazard_c && !flush && fwd_en) exe_sel_d = sel_c;
    case (state_q)
      RUN: begin
        if (hazard_c) begin
          state_d       = STALL;
          stall_event_d = 1'b1;
        end
      end
      STALL: begin
        if (!hazard_c) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (hazard_c && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      exe_sel_q     <= '0;
      stall_event_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      exe_sel_q     <= exe_sel_d;
      stall_event_q <= stall_event_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign exe_sel      = exe_sel_q;
  assign hazard_stall = hazard_c;
  assign stall_event  = stall_event_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_forwarding_hazard_unit;
  localparam int unsigned NS = 3;
  localparam int unsigned NF = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = 2;

  logic            clk = 1'b0;
  logic            rst, id_valid, exe_wb_en, exe_mem_r_en, fwd_en, flush;
  logic [0:0]      stg_wb_en;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]   id_src_used;
  logic [AW-1:0]   exe_dest, stg_dest;
  logic [NS*SW-1:0] exe_sel;
  logic            hazard_stall, stall_event;
  logic [CW-1:0]   stall_count;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  forwarding_hazard_unit #(.NUM_SRC(NS), .NUM_FWD_STAGES(NF), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used), .id_valid(id_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .stg_dest(stg_dest), .stg_wb_en(stg_wb_en), .fwd_en(fwd_en), .flush(flush),
    .exe_sel(exe_sel), .hazard_stall(hazard_stall), .stall_event(stall_event),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: nearest producer position per source, then the mode rules.
  logic       m_h;
  logic [1:0] m_sel [NS];
  always_comb begin
    int         near [NS];
    logic [4:0] pd [2];
    logic       pw [2];
    logic       use_exe, use_any;
    logic [4:0] s;
    pd[0] = exe_dest; pw[0] = exe_wb_en;
    pd[1] = stg_dest; pw[1] = stg_wb_en[0];
    use_exe = 1'b0; use_any = 1'b0; s = '0;
    for (int i = 0; i < int'(NS); i++) begin
      near[i] = -1;
      s = id_src[i*5 +: 5];
      for (int p = 0; p < 2; p++)
        if (near[i] < 0 && id_src_used[i] && s != 0 && pw[p] && s == pd[p]) near[i] = p;
      if (near[i] == 0) use_exe = 1'b1;
      if (near[i] >= 0) use_any = 1'b1;
      m_sel[i] = (fwd_en && near[i] >= 0) ? 2'(near[i] + 1) : 2'd0;
    end
    if (fwd_en) m_h = id_valid && exe_wb_en && exe_mem_r_en && use_exe;
    else        m_h = id_valid && use_any;
    if (rst || flush) m_h = 1'b0;
  end

  logic [1:0] e_sel [NS];
  logic       e_prev, e_ev;
  int         e_cnt;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NS); i++) e_sel[i] = 2'd0;
      e_prev = 1'b0; e_ev = 1'b0; e_cnt = 0;
    end else begin
      for (int i = 0; i < int'(NS); i++)
        e_sel[i] = (id_valid && !m_h && !flush) ? m_sel[i] : 2'd0;
      e_ev   = m_h && !e_prev;
      e_prev = m_h;
      if (m_h && e_cnt < 15) e_cnt = e_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (hazard_stall !== m_h) begin
        errors++;
        $display("FAIL model hazard_stall t=%0t got %0b want %0b", $time, hazard_stall, m_h);
      end
      for (int i = 0; i < int'(NS); i++) begin
        checks++;
        if (exe_sel[i*2 +: 2] !== e_sel[i]) begin
          errors++;
          $display("FAIL model exe_sel[%0d] t=%0t got %0d want %0d", i, $time, exe_sel[i*2 +: 2], e_sel[i]);
        end
      end
      checks++;
      if (stall_event !== e_ev) begin
        errors++;
        $display("FAIL model stall_event t=%0t got %0b want %0b", $time, stall_event, e_ev);
      end
      checks++;
      if (int'(stall_count) != e_cnt || $isunknown(stall_count)) begin
        errors++;
        $display("FAIL model stall_count t=%0t got %0d want %0d", $time, stall_count, e_cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b1; id_src = '0; id_src_used = '0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    stg_dest = '0; stg_wb_en = 1'b0; fwd_en = 1'b1; flush = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    chk("reset exe_sel", 32'(exe_sel), 0);
    chk("reset stall_event", 32'(stall_event), 0);
    chk("reset stall_count", 32'(stall_count), 0);
    chk("reset hazard", 32'(hazard_stall), 0);

    // EXE and MEM both produce r5: EXE wins
    idle();
    id_src[4:0] = 5'd5; id_src_used = 3'b001;
    exe_dest = 5'd5; exe_wb_en = 1'b1; stg_dest = 5'd5; stg_wb_en = 1'b1;
    #2 chk("s36 hazard", 32'(hazard_stall), 0);
    step();
    chk("s36 sel0", 32'(exe_sel[1:0]), 1);

    // load-use on src1=r7
    idle();
    id_src[9:5] = 5'd7; id_src_used = 3'b010;
    exe_dest = 5'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #2 chk("s37 hazard", 32'(hazard_stall), 1);
    step();
    chk("s37 bubble", 32'(exe_sel), 0);
    chk("s37 event", 32'(stall_event), 1);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; stg_dest = 5'd7; stg_wb_en = 1'b1;
    #2 chk("s37 hazard drop", 32'(hazard_stall), 0);
    step();
    chk("s37 sel1", 32'(exe_sel[3:2]), 2);
    chk("s37 event low", 32'(stall_event), 0);

    // r0 never matches
    idle();
    id_src_used = 3'b001; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #2 chk("s38 hazard", 32'(hazard_stall), 0);
    step();
    chk("s38 sel", 32'(exe_sel), 0);

    idle(); rst = 1'b1; step();

    // stall-only mode, r3 walking EXE -> MEM -> WB
    idle();
    fwd_en = 1'b0; id_src[14:10] = 5'd3; id_src_used = 3'b100;
    exe_dest = 5'd3; exe_wb_en = 1'b1;
    #2 chk("s39 hazard A", 32'(hazard_stall), 1);
    step();
    chk("s39 event A", 32'(stall_event), 1);
    chk("s39 count A", 32'(stall_count), 1);
    exe_wb_en = 1'b0; stg_dest = 5'd3; stg_wb_en = 1'b1;
    #2 chk("s39 hazard B", 32'(hazard_stall), 1);
    step();
    chk("s39 event B", 32'(stall_event), 0);
    chk("s39 count B", 32'(stall_count), 2);
    stg_wb_en = 1'b0;
    #2 chk("s39 hazard C", 32'(hazard_stall), 0);
    step();
    chk("s39 count C", 32'(stall_count), 2);
    chk("s39 sel C", 32'(exe_sel), 0);

    // load-use killed by flush
    idle();
    id_src[4:0] = 5'd9; id_src_used = 3'b001;
    exe_dest = 5'd9; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; flush = 1'b1;
    #2 chk("s40 hazard", 32'(hazard_stall), 0);
    step();
    chk("s40 sel", 32'(exe_sel), 0);
    chk("s40 event", 32'(stall_event), 0);

    // saturation, then reset in the middle of the stall
    flush = 1'b0;
    for (int n = 0; n < 20; n++) step();
    chk("s41 saturate", 32'(stall_count), 15);
    rst = 1'b1;
    #2 chk("s41 hazard in rst", 32'(hazard_stall), 0);
    step();
    chk("s41 rst sel", 32'(exe_sel), 0);
    chk("s41 rst event", 32'(stall_event), 0);
    chk("s41 rst count", 32'(stall_count), 0);
    rst = 1'b0;
    #2 chk("s41 hazard after rst", 32'(hazard_stall), 1);
    step();
    chk("s41 run event", 32'(stall_event), 1);
    chk("s41 run count", 32'(stall_count), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_valid     = ($urandom_range(0, 7) != 0);
      id_src       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_src_used  = 3'($urandom_range(0, 7));
      exe_dest     = 5'($urandom_range(0, 7));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      stg_dest     = 5'($urandom_range(0, 7));
      stg_wb_en    = 1'($urandom_range(0, 1));
      fwd_en       = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
